twiddle_gen: RTL



---
 rtl/twiddle_gen.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/twiddle_gen.sv
// twiddle_gen: holds the NTT modulus, Montgomery constant, working twiddle and
// omega/psi banks. Twiddle/omega updates run through a pipelined Montgomery
// multiplier. A stream mode emits tw, tw*w, tw*w^2, ... with backpressure.
module twiddle_gen #(
  parameter int DATA_W    = 32,
  parameter int LOG_R     = 32,
  parameter int NUM_SLOTS = 8,
  parameter int MUL_LAT   = 3,
  parameter int CNT_W     = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [7:0]        cfg_addr_i,
  input  logic [DATA_W-1:0] cfg_wdata_i,
  output logic [DATA_W-1:0] cfg_rdata_o,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic              cmd_inc_i,
  input  logic [CNT_W-1:0]  cmd_cnt_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] twiddle_o,
  output logic [DATA_W-1:0] omega_o,
  output logic [DATA_W-1:0] psi_o,
  output logic [DATA_W-1:0] prime_o,
  output logic [DATA_W-1:0] prime_dash_o
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int PW    = 2 * DATA_W;
  localparam int RW    = LOG_R + DATA_W + 1;

  localparam logic [2:0] OP_UPD_TW    = 3'd0;
  localparam logic [2:0] OP_SQR_OMEGA = 3'd1;
  localparam logic [2:0] OP_TW_PSI    = 3'd2;
  localparam logic [2:0] OP_INV_TW    = 3'd3;
  localparam logic [2:0] OP_PSI_OMEGA = 3'd4;
  localparam logic [2:0] OP_STREAM    = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_EMIT} state_t;

  // Montgomery reduction of a full product t: returns t * R^-1 mod q.
  // m is computed in LOG_R-bit context so the multiply wraps mod R exactly;
  // the sum t + m*q is held in RW bits so nothing is truncated.
  function automatic logic [DATA_W-1:0] mont_reduce(
    input logic [PW-1:0]     t,
    input logic [DATA_W-1:0] q,
    input logic [DATA_W-1:0] qd
  );
    logic [RW-1:0]    t_w;
    logic [LOG_R-1:0] t_lo;
    logic [LOG_R-1:0] qd_r;
    logic [LOG_R-1:0] m;
    logic [RW-1:0]    u_w;
    t_w  = RW'(t);
    t_lo = t_w[LOG_R-1:0];
    qd_r = LOG_R'(qd);
    m    = t_lo * qd_r;
    u_w  = (t_w + RW'(m) * RW'(q)) >> LOG_R;
    if (u_w >= RW'(q))
      u_w = u_w - RW'(q);
    return DATA_W'(u_w);
  endfunction

  state_t            state;
  logic [DATA_W-1:0] prime_q;
  logic [DATA_W-1:0] pdash_q;
  logic [DATA_W-1:0] tw_q;
  logic [IDX_W-1:0]  om_idx;
  logic [IDX_W-1:0]  psi_idx;
  logic [DATA_W-1:0] om_bank  [NUM_SLOTS];
  logic [DATA_W-1:0] psi_bank [NUM_SLOTS];
  logic [2:0]        op_q;
  logic              inc_q;
  logic [CNT_W-1:0]  rem_q;
  logic              ready_q;
  logic              busy_q;
  logic              oval_q;
  logic [DATA_W-1:0] odata_q;

  logic [PW-1:0]      prod_p [MUL_LAT];
  logic [MUL_LAT-1:0] vld_p;

  logic [DATA_W-1:0] omega_cur;
  logic [DATA_W-1:0] psi_cur;
  logic              cmd_acc;
  logic              emit_hs;
  logic              issue;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_res;
  logic              mul_done;
  logic              cfg_wr_ok;
  logic              bank_hit;

  assign omega_cur = om_bank[om_idx];
  assign psi_cur   = psi_bank[psi_idx];
  assign cmd_acc   = cmd_valid_i && ready_q;
  assign emit_hs   = oval_q && out_ready_i;
  assign issue     = (cmd_acc && (cmd_op_i == OP_UPD_TW || cmd_op_i == OP_SQR_OMEGA)) || emit_hs;
  assign mul_a     = (cmd_acc && cmd_op_i == OP_SQR_OMEGA) ? omega_cur : tw_q;
  assign mul_b     = omega_cur;
  assign mul_done  = vld_p[MUL_LAT-1];
  assign mul_res   = mont_reduce(prod_p[MUL_LAT-1], prime_q, pdash_q);
  assign cfg_wr_ok = cfg_we_i && !busy_q;
  assign bank_hit  = int'(cfg_addr_i[3:0]) < NUM_SLOTS;

  // Stage p0: full-width product captured at issue; later stages delay it,
  // and the reduction sits in front of the write-back after the last stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p <= '0;
      for (int i = 0; i < MUL_LAT; i++)
        prod_p[i] <= '0;
    end else begin
      vld_p[0]  <= issue;
      prod_p[0] <= PW'(mul_a) * PW'(mul_b);
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        prod_p[i] <= prod_p[i-1];
      end
    end
  end

  // Control FSM and architectural state; command effects are written after
  // config writes so a completing command's index increment wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      prime_q <= '0;
      pdash_q <= '0;
      tw_q    <= '0;
      om_idx  <= '0;
      psi_idx <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        om_bank[i]  <= '0;
        psi_bank[i] <= '0;
      end
      op_q    <= '0;
      inc_q   <= 1'b0;
      rem_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      oval_q  <= 1'b0;
      odata_q <= '0;
    end else begin
      if (cfg_wr_ok) begin
        if (cfg_addr_i == 8'd0)
          prime_q <= cfg_wdata_i;
        else if (cfg_addr_i == 8'd1)
          pdash_q <= cfg_wdata_i;
        else if (cfg_addr_i == 8'd2)
          tw_q <= cfg_wdata_i;
        else if (cfg_addr_i == 8'd3)
          om_idx <= cfg_wdata_i[IDX_W-1:0];
        else if (cfg_addr_i == 8'd4)
          psi_idx <= cfg_wdata_i[IDX_W-1:0];
        else if (cfg_addr_i[7:4] == 4'd1 && bank_hit)
          om_bank[cfg_addr_i[IDX_W-1:0]] <= cfg_wdata_i;
        else if (cfg_addr_i[7:4] == 4'd2 && bank_hit)
          psi_bank[cfg_addr_i[IDX_W-1:0]] <= cfg_wdata_i;
      end

      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (cmd_acc) begin
            op_q  <= cmd_op_i;
            inc_q <= cmd_inc_i;
            rem_q <= cmd_cnt_i;
            case (cmd_op_i)
              OP_TW_PSI: begin
                tw_q <= psi_cur;
                if (cmd_inc_i)
                  psi_idx <= psi_idx + IDX_W'(1);
              end
              OP_INV_TW: begin
                tw_q <= (tw_q == '0) ? '0 : prime_q - tw_q;
              end
              OP_PSI_OMEGA: begin
                psi_bank[psi_idx] <= omega_cur;
                if (cmd_inc_i)
                  psi_idx <= psi_idx + IDX_W'(1);
              end
              OP_UPD_TW, OP_SQR_OMEGA: begin
                state   <= S_MUL;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
              OP_STREAM: begin
                if (cmd_cnt_i != '0) begin
                  state   <= S_EMIT;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  oval_q  <= 1'b1;
                  odata_q <= tw_q;
                end
              end
              default: ;
            endcase
          end
        end

        S_MUL: begin
          if (mul_done) begin
            if (op_q == OP_SQR_OMEGA)
              om_bank[om_idx] <= mul_res;
            else
              tw_q <= mul_res;
            if (op_q == OP_STREAM && rem_q != '0) begin
              state   <= S_EMIT;
              oval_q  <= 1'b1;
              odata_q <= mul_res;
            end else begin
              state   <= S_IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              if (inc_q)
                om_idx <= om_idx + IDX_W'(1);
            end
          end
        end

        S_EMIT: begin
          if (emit_hs) begin
            oval_q <= 1'b0;
            rem_q  <= rem_q - CNT_W'(1);
            state  <= S_MUL;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    if (cfg_addr_i == 8'd0)
      cfg_rdata_o = prime_q;
    else if (cfg_addr_i == 8'd1)
      cfg_rdata_o = pdash_q;
    else if (cfg_addr_i == 8'd2)
      cfg_rdata_o = tw_q;
    else if (cfg_addr_i == 8'd3)
      cfg_rdata_o = DATA_W'(om_idx);
    else if (cfg_addr_i == 8'd4)
      cfg_rdata_o = DATA_W'(psi_idx);
    else if (cfg_addr_i[7:4] == 4'd1 && bank_hit)
      cfg_rdata_o = om_bank[cfg_addr_i[IDX_W-1:0]];
    else if (cfg_addr_i[7:4] == 4'd2 && bank_hit)
      cfg_rdata_o = psi_bank[cfg_addr_i[IDX_W-1:0]];
  end

  assign cmd_ready_o  = ready_q;
  assign busy_o       = busy_q;
  assign out_valid_o  = oval_q;
  assign out_data_o   = odata_q;
  assign twiddle_o    = tw_q;
  assign omega_o      = omega_cur;
  assign psi_o        = psi_cur;
  assign prime_o      = prime_q;
  assign prime_dash_o = pdash_q;

endmodule
